pipe_ctrl: RTL



---
 rtl/pipe_ctrl_pkg.sv | 88 ++++++++
 rtl/pipe_ctrl_decode.sv | 35 +++
 rtl/pipe_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: opcodes, ALU operation
// codes, per-stage control bundles and the bubble constants.
package pipe_ctrl_pkg;

    localparam int OPC_WIDTH   = 6;
    localparam int ALUOP_WIDTH = 3;

    typedef enum logic [OPC_WIDTH-1:0] {
        OPC_R    = 6'b000000,
        OPC_J    = 6'b000010,
        OPC_BEQ  = 6'b000100,
        OPC_ADDI = 6'b001000,
        OPC_SLTI = 6'b001010,
        OPC_ANDI = 6'b001100,
        OPC_ORI  = 6'b001101,
        OPC_LW   = 6'b100011,
        OPC_SW   = 6'b101011
    } opc_e;

    typedef enum logic [ALUOP_WIDTH-1:0] {
        ALU_ADD   = 3'b000,  // address generation and addi
        ALU_SUB   = 3'b001,  // beq compare
        ALU_FUNCT = 3'b010,  // R-type: the ALU decodes the funct field
        ALU_SLT   = 3'b100,
        ALU_AND   = 3'b101,
        ALU_OR    = 3'b111
    } alu_op_e;

    // Fields consumed in EX
    typedef struct packed {
        logic    reg_dst;
        alu_op_e alu_op;
        logic    alu_src;
    } ex_ctrl_t;

    // Fields consumed in MEM
    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    // Fields consumed in WB
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    // Full decoded bundle; each stage register keeps only what is still ahead of it
    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_t;

    localparam ctrl_t     CTRL_BUBBLE = '0;
    localparam mem_ctrl_t MEM_BUBBLE  = '0;
    localparam wb_ctrl_t  WB_BUBBLE   = '0;

    // Build a bundle in the column order of the decode table
    function automatic ctrl_t make_ctrl(
        input logic    reg_dst,
        input alu_op_e alu_op,
        input logic    alu_src,
        input logic    branch,
        input logic    mem_read,
        input logic    mem_write,
        input logic    reg_write,
        input logic    mem_to_reg
    );
        ctrl_t c;
        c.ex.reg_dst     = reg_dst;
        c.ex.alu_op      = alu_op;
        c.ex.alu_src     = alu_src;
        c.mem.branch     = branch;
        c.mem.mem_read   = mem_read;
        c.mem.mem_write  = mem_write;
        c.wb.reg_write   = reg_write;
        c.wb.mem_to_reg  = mem_to_reg;
        return c;
    endfunction

    // Opcodes whose rt field is a source operand rather than a destination
    function automatic logic uses_rt(input logic [OPC_WIDTH-1:0] opc);
        return (opc == OPC_R) || (opc == OPC_SW) || (opc == OPC_BEQ);
    endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Purely combinational opcode decoder. Unknown opcodes and jumps produce the
// all-zero bundle so that nothing downstream ever sees X.
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opc,
    output ctrl_t            ctrl,
    output logic             is_jump,
    output logic             unknown
);

    // Map each opcode to its control bundle
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        ctrl    = CTRL_BUBBLE;
        is_jump = 1'b0;
        unknown = 1'b0;
        case (opc)
            //                    dst   aluop      src   br    rd    wr    rw    m2r
            OPC_R:    ctrl = make_ctrl(1'b1, ALU_FUNCT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            OPC_LW:   ctrl = make_ctrl(1'b0, ALU_ADD,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            OPC_SW:   ctrl = make_ctrl(1'b0, ALU_ADD,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            OPC_BEQ:  ctrl = make_ctrl(1'b0, ALU_SUB,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            OPC_ADDI: ctrl = make_ctrl(1'b0, ALU_ADD,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            OPC_SLTI: ctrl = make_ctrl(1'b0, ALU_SLT,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            OPC_ANDI: ctrl = make_ctrl(1'b0, ALU_AND,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            OPC_ORI:  ctrl = make_ctrl(1'b0, ALU_OR,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            OPC_J:    is_jump = 1'b1;
            default:  unknown = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: decodes ID, carries the control bundle and
// destination register through EX/MEM/WB, and resolves load-use stalls,
// jumps and taken-branch flushes. Counts stall and flush cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int OPC_W   = 6,
    parameter int RA_W    = 5,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opc,
    input  logic [RA_W-1:0]    rs,
    input  logic [RA_W-1:0]    rt,
    input  logic [RA_W-1:0]    rd,
    input  logic               branch_taken,
    output logic               stall,
    output logic               flush_ifid,
    output logic               jump,
    output logic               ex_reg_dst,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic               mem_branch,
    output logic               mem_read,
    output logic               mem_write,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic [RA_W-1:0]    wb_dst,
    output logic               illegal,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    ctrl_t           id_ctrl;
    logic            id_jump;
    logic            id_unknown;
    ctrl_t           id_bundle;
    logic [RA_W-1:0] id_dst;
    logic            load_use;

    ctrl_t           idex_ctrl;
    logic [RA_W-1:0] idex_dst;
    mem_ctrl_t       exmem_mem;
    wb_ctrl_t        exmem_wb;
    logic [RA_W-1:0] exmem_dst;
    wb_ctrl_t        memwb_wb;
    logic [RA_W-1:0] memwb_dst;

    pipe_ctrl_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .opc     (opc),
        .ctrl    (id_ctrl),
        .is_jump (id_jump),
        .unknown (id_unknown)
    );

    // Jumps and unknown opcodes enter the pipe as a full bubble, destination included
    always_comb begin
        id_bundle = CTRL_BUBBLE;
        id_dst    = '0;
        if (!(id_jump || id_unknown)) begin
            id_bundle = id_ctrl;
            id_dst    = id_ctrl.ex.reg_dst ? rd : rt;
        end
    end

    // A load in EX whose result a dependent ID instruction needs; $0 never hazards
    assign load_use = idex_ctrl.mem.mem_read && (idex_dst != '0) &&
                      ((idex_dst == rs) || ((idex_dst == rt) && uses_rt(opc)));

    // A taken branch overrides everything. A jump waits out a stall, because IF/ID
    // is frozen then and the jump is seen again in the next cycle.
    assign stall      = !rst && !branch_taken && load_use;
    assign jump       = !rst && !branch_taken && !load_use && id_jump;
    assign flush_ifid = !rst && (branch_taken || jump);

    // Stage registers: stalls bubble ID/EX only, taken branches bubble ID/EX and EX/MEM
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            idex_ctrl <= CTRL_BUBBLE;
            idex_dst  <= '0;
            exmem_mem <= MEM_BUBBLE;
            exmem_wb  <= WB_BUBBLE;
            exmem_dst <= '0;
            memwb_wb  <= WB_BUBBLE;
            memwb_dst <= '0;
        end else begin
            memwb_wb  <= exmem_wb;
            memwb_dst <= exmem_dst;
            if (branch_taken) begin
                exmem_mem <= MEM_BUBBLE;
                exmem_wb  <= WB_BUBBLE;
                exmem_dst <= '0;
            end else begin
                exmem_mem <= idex_ctrl.mem;
                exmem_wb  <= idex_ctrl.wb;
                exmem_dst <= idex_dst;
            end
            if (branch_taken || stall) begin
                idex_ctrl <= CTRL_BUBBLE;
                idex_dst  <= '0;
            end else begin
                idex_ctrl <= id_bundle;
                idex_dst  <= id_dst;
            end
        end
    end

    // Illegal-opcode pulse and saturating stall/flush counters
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            // A stalled instruction is seen again next cycle; a flushed one is discarded
            illegal <= id_unknown && !stall && !branch_taken;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_ifid && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign ex_reg_dst    = idex_ctrl.ex.reg_dst;
    assign ex_alu_op     = idex_ctrl.ex.alu_op;
    assign ex_alu_src    = idex_ctrl.ex.alu_src;
    assign mem_branch    = exmem_mem.branch;
    assign mem_read      = exmem_mem.mem_read;
    assign mem_write     = exmem_mem.mem_write;
    assign wb_reg_write  = memwb_wb.reg_write;
    assign wb_mem_to_reg = memwb_wb.mem_to_reg;
    assign wb_dst        = memwb_dst;

endmodule
